// File: rtl/cnt_fsm_bench.sv
// NCH up/down counters of CNT_W bits sequenced by an IDLE/RUN/HOLD/DONE controller.
// Optional feature: define CNT_SAT_EN to make counters saturate instead of wrapping.
module cnt_fsm_bench #(
    parameter int CNT_W    = 8,
    parameter int NCH      = 2,
    parameter int TERM     = 200,
    parameter int HOLD_CYC = 4
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 G0,
    input  logic                 G1,
    input  logic                 G2,
    input  logic [NCH-1:0]       EN,
    output logic [NCH*CNT_W-1:0] CNT,
    output logic [1:0]           STATE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int              HW      = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] TERM_V = CNT_W'(TERM);
    localparam logic [CNT_W-1:0] ZERO_V = '0;
    localparam logic [CNT_W-1:0] MAX_V  = '1;
    localparam logic [HW-1:0]    HOLD_LD = HW'(HOLD_CYC - 1);

    state_t               state_q, state_d;
    logic [NCH*CNT_W-1:0] cnt_q, cnt_d, cnt_step;
    logic [NCH-1:0]       hit_v;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 dir_q, dir_d;
    logic                 err_q, err_d;
    logic                 busy_q, done_q;

    // Per-channel next value and terminal detection, both based on the value the counter is about to take.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] cur, nxt;
        assign cur = cnt_q[i*CNT_W +: CNT_W];
`ifdef CNT_SAT_EN
        always_comb begin
            if (dir_q) nxt = (cur == ZERO_V) ? cur : cur - 1'b1;
            else       nxt = (cur == MAX_V)  ? cur : cur + 1'b1;
        end
        assign hit_v[i] = EN[i] && ((nxt == (dir_q ? ZERO_V : TERM_V)) ||
                                    (nxt == (dir_q ? ZERO_V : MAX_V)));
`else
        assign nxt      = dir_q ? cur - 1'b1 : cur + 1'b1;
        assign hit_v[i] = EN[i] && (nxt == (dir_q ? ZERO_V : TERM_V));
`endif
        assign cnt_step[i*CNT_W +: CNT_W] = EN[i] ? nxt : cur;
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        hold_d  = hold_q;
        err_d   = err_q;
        if (G0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (G1) begin
                        state_d = S_RUN;
                        dir_d   = G2;
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_step;
                    if (|hit_v) begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_LD;
                    end
                end
                S_HOLD: begin
                    if (G1) err_d = 1'b1;
                    if (hold_q == '0) state_d = S_DONE;
                    else              hold_d  = hold_q - 1'b1;
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            hold_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign CNT   = cnt_q;
    assign STATE = state_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_cnt_fsm_bench.sv
// Self-checking bench for cnt_fsm_bench: vector table, directed corner sequences and a random run against a reference model.
module tb_cnt_fsm_bench;

    localparam int CNT_W    = 8;
    localparam int NCH      = 2;
    localparam int TERM     = 200;
    localparam int HOLD_CYC = 4;
    localparam int MODV     = 1 << CNT_W;
`ifdef CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                 CK = 1'b0;
    logic                 RN, G0, G1, G2;
    logic [NCH-1:0]       EN;
    logic [NCH*CNT_W-1:0] CNT;
    logic [1:0]           STATE;
    logic                 BUSY, DONE, ERR;

    cnt_fsm_bench #(.CNT_W(CNT_W), .NCH(NCH), .TERM(TERM), .HOLD_CYC(HOLD_CYC)) dut (
        .CK(CK), .RN(RN), .G0(G0), .G1(G1), .G2(G2), .EN(EN),
        .CNT(CNT), .STATE(STATE), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CK = ~CK;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase numbers follow the published state codes; hold_left counts remaining HOLD cycles.
    int m_cnt[NCH];
    int m_phase, m_dir, m_err, m_hold_left;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
        m_phase = 0; m_dir = 0; m_err = 0; m_hold_left = 0;
    endfunction

    function automatic void model_edge(input bit g0, g1, g2, input bit [NCH-1:0] en);
        bit term;
        int v;
        if (g0) begin
            for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
            m_phase = 0; m_err = 0;
            return;
        end
        case (m_phase)
            0: if (g1) begin m_phase = 1; m_dir = g2; end
            1: begin
                term = 1'b0;
                for (int c = 0; c < NCH; c++) begin
                    if (en[c]) begin
                        v = (m_dir != 0) ? m_cnt[c] - 1 : m_cnt[c] + 1;
                        if (v < 0)     v = SAT ? 0 : v + MODV;
                        if (v >= MODV) v = SAT ? MODV - 1 : v - MODV;
                        if (v == ((m_dir != 0) ? 0 : TERM)) term = 1'b1;
                        if (SAT && v == ((m_dir != 0) ? 0 : MODV - 1)) term = 1'b1;
                        m_cnt[c] = v;
                    end
                end
                if (term) begin m_phase = 2; m_hold_left = HOLD_CYC; end
            end
            2: begin
                if (g1) m_err = 1;
                m_hold_left--;
                if (m_hold_left == 0) m_phase = 3;
            end
            default: m_phase = 0;
        endcase
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [NCH*CNT_W-1:0] e;
        for (int c = 0; c < NCH; c++) e[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        check("model_cnt",   CNT,   e);
        check("model_state", STATE, m_phase);
        check("model_busy",  BUSY,  m_phase != 0);
        check("model_done",  DONE,  m_phase == 3);
        check("model_err",   ERR,   m_err);
    endtask

    task automatic tick(input bit g0, g1, g2, input bit [NCH-1:0] en);
        G0 = g0; G1 = g1; G2 = g2; EN = en;
        @(posedge CK);
        model_edge(g0, g1, g2, en);
        #1;
        check_model();
    endtask

    typedef struct {
        bit       g0, g1, g2;
        bit [1:0] en;
        int       st;
        bit       busy, done, err;
        int       c0, c1;
    } vec_t;
    vec_t tbl[13];

    int n;

    initial begin
        tbl[0]  = '{0, 1, 0, 2'b11, 1, 1, 0, 0,   0,   0};
        tbl[1]  = '{0, 0, 0, 2'b01, 1, 1, 0, 0,   1,   0};
        tbl[2]  = '{0, 0, 0, 2'b10, 1, 1, 0, 0,   1,   1};
        tbl[3]  = '{0, 0, 0, 2'b11, 1, 1, 0, 0,   2,   2};
        tbl[4]  = '{0, 0, 0, 2'b00, 1, 1, 0, 0,   2,   2};
        tbl[5]  = '{0, 0, 1, 2'b01, 1, 1, 0, 0,   3,   2};
        tbl[6]  = '{0, 1, 0, 2'b01, 1, 1, 0, 0,   4,   2};
        tbl[7]  = '{1, 1, 0, 2'b11, 0, 0, 0, 0,   0,   0};
        tbl[8]  = '{0, 1, 1, 2'b00, 1, 1, 0, 0,   0,   0};
        tbl[9]  = '{0, 0, 0, 2'b01, 1, 1, 0, 0, 255,   0};
        tbl[10] = '{0, 0, 0, 2'b10, 1, 1, 0, 0, 255, 255};
        tbl[11] = '{0, 0, 1, 2'b11, 1, 1, 0, 0, 254, 254};
        tbl[12] = '{1, 0, 0, 2'b00, 0, 0, 0, 0,   0,   0};

        RN = 1'b0; G0 = 1'b0; G1 = 1'b0; G2 = 1'b0; EN = '0;
        model_reset();
        #12;
        check("rst_cnt", CNT, 0);
        check("rst_state", STATE, 0);
        check("rst_flags", {BUSY, DONE, ERR}, 0);
        @(negedge CK) RN = 1'b1;

        // Vector table.
        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].g0, tbl[i].g1, tbl[i].g2, tbl[i].en);
            check("tbl_state", STATE, tbl[i].st);
            check("tbl_busy",  BUSY,  tbl[i].busy);
            check("tbl_done",  DONE,  tbl[i].done);
            check("tbl_err",   ERR,   tbl[i].err);
            check("tbl_cnt0",  CNT[7:0],  tbl[i].c0);
            check("tbl_cnt1",  CNT[15:8], tbl[i].c1);
        end

        // Up count from 0 to TERM on channel 0, then HOLD/DONE timing.
        tick(0, 1, 0, 2'b01);
        n = 0;
        while (STATE != 2'd2 && n < 300) begin tick(0, 0, 0, 2'b01); n++; end
        check("up_run_cycles", n, 200);
        check("up_cnt0", CNT[7:0], 200);
        check("up_cnt1", CNT[15:8], 0);
        for (int k = 0; k < HOLD_CYC - 1; k++) begin
            tick(0, 0, 0, 2'b01);
            check("up_hold_state", STATE, 2);
        end
        tick(0, 0, 0, 2'b01);
        check("up_done_state", STATE, 3);
        check("up_done_pulse", DONE, 1);
        tick(0, 0, 0, 2'b01);
        check("up_idle_state", STATE, 0);
        check("up_done_low", DONE, 0);

        // Restart from 200: wraps (or saturates), then G1 in the second HOLD cycle sets ERR.
        tick(0, 1, 0, 2'b01);
        n = 0;
        while (STATE != 2'd2 && n < 300) begin tick(0, 0, 0, 2'b01); n++; end
        check("wrap_run_cycles", n, SAT ? 55 : 256);
        check("wrap_cnt0", CNT[7:0], SAT ? 255 : 200);
        tick(0, 0, 0, 2'b01);
        check("err_pre", ERR, 0);
        tick(0, 1, 0, 2'b01);
        check("err_set", ERR, 1);
        check("err_state", STATE, 2);
        tick(0, 0, 0, 2'b01);
        tick(0, 0, 0, 2'b01);
        check("err_done", {STATE, ERR}, {2'd3, 1'b1});
        tick(0, 1, 0, 2'b01);
        check("done_ignores_g1", {STATE, ERR}, {2'd0, 1'b1});
        tick(0, 1, 1, 2'b01);
        check("err_after_start", {STATE, ERR}, {2'd1, 1'b1});
        tick(1, 0, 0, 2'b00);
        check("err_cleared", {STATE, ERR}, {2'd0, 1'b0});

        // Down count from 0 wraps to 255 and terminates on reaching 0.
        tick(0, 1, 1, 2'b01);
        tick(0, 0, 0, 2'b01);
        check("down_first", CNT[7:0], SAT ? 0 : 255);
        n = 1;
        while (STATE != 2'd2 && n < 300) begin tick(0, 0, 0, 2'b01); n++; end
        check("down_run_cycles", n, SAT ? 1 : 256);
        check("down_cnt0", CNT[7:0], 0);
        for (int k = 0; k < HOLD_CYC + 1; k++) tick(0, 0, 0, 2'b00);
        check("down_back_idle", STATE, 0);

        // Asynchronous reset mid-RUN at CNT0=37.
        tick(0, 1, 0, 2'b01);
        for (int k = 0; k < 37; k++) tick(0, 0, 0, 2'b01);
        check("pre_rst_cnt0", CNT[7:0], 37);
        #2 RN = 1'b0;
        #1;
        model_reset();
        check("async_rst_cnt", CNT, 0);
        check("async_rst_state", STATE, 0);
        check("async_rst_flags", {BUSY, DONE, ERR}, 0);
        @(negedge CK) RN = 1'b1;

        // Clear beats start in RUN at CNT0=90.
        tick(0, 1, 0, 2'b01);
        for (int k = 0; k < 90; k++) tick(0, 0, 0, 2'b01);
        check("pre_clr_cnt0", CNT[7:0], 90);
        tick(1, 1, 0, 2'b01);
        check("clr_state", STATE, 0);
        check("clr_cnt", CNT, 0);
        check("clr_done", DONE, 0);

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            tick($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
